// File: rtl/sha256_block_loader_if.sv
// Message word stream into the SHA-256 block loader.
// Ports: in_data/in_valid/in_last/in_bytes from the source, in_ready back.
interface sha256_block_loader_if;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_last;
   logic [1:0]  in_bytes;
   logic        in_ready;

   modport master (
      output in_data, in_valid, in_last, in_bytes,
      input  in_ready
   );

   modport slave (
      input  in_data, in_valid, in_last, in_bytes,
      output in_ready
   );
endinterface

// File: rtl/sha256_block_loader.sv
// SHA-256 block loader: packs a big-endian word stream into padded
// 512-bit blocks (0x80, zero fill, 64-bit bit length) for the block store.
// Ports: clock, reset (async, active high), start, src (word stream),
//   message/indirizzo/wr_en (block write), done, last_addr,
//   indirizzo_nonce/width (nonce location), overflow.
// Option: define LOADER_BYTESWAP_EN to byte-reverse each accepted word.
module sha256_block_loader #(
   parameter int MAX_BLOCKS = 2000,
   parameter int NONCE_BYTE = 76
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        start,
   sha256_block_loader_if.slave        src,
   output logic [511:0]                message,
   output logic [15:0]                 indirizzo,
   output logic                        wr_en,
   output logic                        done,
   output logic [15:0]                 last_addr,
   output logic [15:0]                 indirizzo_nonce,
   output logic [8:0]                  width,
   output logic                        overflow
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_COLLECT = 3'd1;
   localparam logic [2:0] S_PAD     = 3'd2;
   localparam logic [2:0] S_LEN     = 3'd3;
   localparam logic [2:0] S_WRITE   = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   localparam logic [15:0] MAX_ADDR   = 16'(MAX_BLOCKS);
   localparam logic [15:0] NONCE_ADDR = 16'(NONCE_BYTE / 64);
   localparam logic [8:0]  NONCE_MSB  = 9'(511 - 8 * (NONCE_BYTE % 64));

   logic [2:0]  state;
   logic [2:0]  after_wr;
   logic [31:0] blk [16];
   logic [4:0]  ptr;
   logic [63:0] cnt;
   logic [15:0] addr;
   logic [1:0]  last_bytes;
   logic        carry;

   logic        accept;
   logic [31:0] word_in;
   logic [63:0] inc;
   logic [511:0] blk_flat;
   logic [4:0]  pad_idx;
   logic [31:0] pad_word;
   logic [31:0] last_w;

   assign src.in_ready = (state == S_COLLECT);
   assign accept = src.in_valid && (state == S_COLLECT);

`ifdef LOADER_BYTESWAP_EN
   assign word_in = {src.in_data[7:0], src.in_data[15:8],
                     src.in_data[23:16], src.in_data[31:24]};
`else
   assign word_in = src.in_data;
`endif

   assign inc = (src.in_last && src.in_bytes != 2'd0)
              ? 64'(src.in_bytes) : 64'd4;

   always_comb begin
      blk_flat = '0;
      for (int i = 0; i < 16; i++)
         blk_flat[511 - 32 * i -: 32] = blk[i];
   end

   // Where the 0x80 marker lands: inside the partial last word,
   // or in the word after a full one (16 = next block).
   assign last_w = blk[4'(ptr - 5'd1)];

   always_comb begin
      pad_idx  = ptr;
      pad_word = 32'h8000_0000;
      if (last_bytes != 2'd0) begin
         pad_idx = ptr - 5'd1;
         unique case (1'b1)
            last_bytes == 2'd1: pad_word = {last_w[31:24], 24'h80_0000};
            last_bytes == 2'd2: pad_word = {last_w[31:16], 16'h8000};
            default:            pad_word = {last_w[31:8], 8'h80};
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= S_IDLE;
         after_wr        <= S_COLLECT;
         for (int i = 0; i < 16; i++) blk[i] <= '0;
         ptr             <= '0;
         cnt             <= '0;
         addr            <= '0;
         last_bytes      <= '0;
         carry           <= 1'b0;
         message         <= '0;
         indirizzo       <= '0;
         wr_en           <= 1'b0;
         done            <= 1'b0;
         last_addr       <= '0;
         indirizzo_nonce <= '0;
         width           <= '0;
         overflow        <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         unique case (state)
            S_IDLE, S_DONE: begin
               if (state == S_DONE) begin
                  done            <= 1'b1;
                  indirizzo_nonce <= NONCE_ADDR;
                  width           <= NONCE_MSB;
               end
               if (start) begin
                  done     <= 1'b0;
                  overflow <= 1'b0;
                  addr     <= '0;
                  cnt      <= '0;
                  ptr      <= '0;
                  carry    <= 1'b0;
                  for (int i = 0; i < 16; i++) blk[i] <= '0;
                  state    <= S_COLLECT;
               end
            end
            S_COLLECT: begin
               if (accept) begin
                  blk[ptr[3:0]] <= word_in;
                  ptr           <= ptr + 5'd1;
                  cnt           <= cnt + inc;
                  if (src.in_last) begin
                     last_bytes <= src.in_bytes;
                     state      <= S_PAD;
                  end else if (ptr == 5'd15) begin
                     after_wr <= S_COLLECT;
                     state    <= S_WRITE;
                  end
               end
            end
            S_PAD: begin
               if (pad_idx < 5'd16) blk[pad_idx[3:0]] <= pad_word;
               for (int i = 0; i < 16; i++)
                  if (5'(i) > pad_idx) blk[i] <= '0;
               if (pad_idx <= 5'd13) begin
                  state <= S_LEN;
               end else begin
                  // No room for the length: spill into a follow-on block.
                  carry    <= (pad_idx == 5'd16);
                  after_wr <= S_LEN;
                  state    <= S_WRITE;
               end
            end
            S_LEN: begin
               blk[14]  <= cnt[60:29];
               blk[15]  <= {cnt[28:0], 3'b000};
               after_wr <= S_DONE;
               state    <= S_WRITE;
            end
            S_WRITE: begin
               if (addr == MAX_ADDR) begin
                  overflow  <= 1'b1;
                  last_addr <= MAX_ADDR - 16'd1;
                  state     <= S_DONE;
               end else begin
                  wr_en     <= 1'b1;
                  message   <= blk_flat;
                  indirizzo <= addr;
                  addr      <= addr + 16'd1;
                  ptr       <= '0;
                  for (int i = 0; i < 16; i++) blk[i] <= '0;
                  if (carry) blk[0] <= 32'h8000_0000;
                  carry     <= 1'b0;
                  if (after_wr == S_DONE) last_addr <= addr;
                  state     <= after_wr;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_block_loader.sv
// Bench for sha256_block_loader: table rows, random messages against a
// byte-level FIPS padding model, and hand sequences for reset/overflow.
module tb_sha256_block_loader;

   localparam int NB = 76;
   localparam logic [15:0] EXP_NADDR = 16'(NB / 64);
   localparam logic [8:0]  EXP_WIDTH = 9'(511 - 8 * (NB % 64));
   localparam logic [511:0] ABC =
      {32'h6162_6380, 416'h0, 32'h0, 32'h0000_0018};

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic start1 = 1'b0;
   logic start2 = 1'b0;
   logic [31:0] d_data = '0;
   logic d_valid = 1'b0;
   logic d_last = 1'b0;
   logic [1:0] d_bytes = '0;
   bit sel_v = 1'b0;

   int checks = 0;
   int errors = 0;

   sha256_block_loader_if if1 ();
   sha256_block_loader_if if2 ();

   assign if1.in_data  = d_data;
   assign if1.in_valid = d_valid;
   assign if1.in_last  = d_last;
   assign if1.in_bytes = d_bytes;
   assign if2.in_data  = d_data;
   assign if2.in_valid = d_valid;
   assign if2.in_last  = d_last;
   assign if2.in_bytes = d_bytes;

   logic [511:0] msg1, msg2;
   logic [15:0]  ind1, ind2, la1, la2, nad1, nad2;
   logic         wr1, wr2, done1, done2, ovf1, ovf2;
   logic [8:0]   wid1, wid2;

   sha256_block_loader dut1 (
      .clock(clock), .reset(reset), .start(start1), .src(if1),
      .message(msg1), .indirizzo(ind1), .wr_en(wr1), .done(done1),
      .last_addr(la1), .indirizzo_nonce(nad1), .width(wid1),
      .overflow(ovf1)
   );

   sha256_block_loader #(.MAX_BLOCKS(2)) dut2 (
      .clock(clock), .reset(reset), .start(start2), .src(if2),
      .message(msg2), .indirizzo(ind2), .wr_en(wr2), .done(done2),
      .last_addr(la2), .indirizzo_nonce(nad2), .width(wid2),
      .overflow(ovf2)
   );

   logic rdy_s, done_s, ovf_s;
   logic [15:0] la_s, nad_s;
   logic [8:0] wid_s;
   assign rdy_s  = sel_v ? if2.in_ready : if1.in_ready;
   assign done_s = sel_v ? done2 : done1;
   assign ovf_s  = sel_v ? ovf2 : ovf1;
   assign la_s   = sel_v ? la2 : la1;
   assign nad_s  = sel_v ? nad2 : nad1;
   assign wid_s  = sel_v ? wid2 : wid1;

   always #5 clock = ~clock;

   logic [7:0]   msg_q[$];
   logic [511:0] exp_q[$];
   logic [15:0]  q1a[$], q2a[$];
   logic [511:0] q1d[$], q2d[$];
   int cyc = 0;
   int lw1 = 0;
   int dr1 = 0;
   logic done1_d = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (wr1) begin
         q1a.push_back(ind1);
         q1d.push_back(msg1);
         lw1 = cyc;
      end
      if (done1 && !done1_d) dr1 = cyc;
      done1_d = done1;
      if (wr2) begin
         q2a.push_back(ind2);
         q2d.push_back(msg2);
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic chk512(input string nm, input logic [511:0] act,
                         input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [511:0] b,
                                           input int k);
      return b[511 - 32 * k -: 32];
   endfunction

   // Standard padding on the byte string, then cut into 64-byte blocks.
   task automatic build_model();
      logic [7:0] p[$];
      logic [63:0] bitlen;
      logic [511:0] b;
      p = msg_q;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      bitlen = 64'(msg_q.size()) * 64'd8;
      for (int k = 7; k >= 0; k--) p.push_back(bitlen[8 * k +: 8]);
      exp_q.delete();
      for (int bi = 0; bi < p.size() / 64; bi++) begin
         b = '0;
         for (int j = 0; j < 64; j++)
            b[511 - 8 * j -: 8] = p[64 * bi + j];
         exp_q.push_back(b);
      end
   endtask

   task automatic send_msg(input bit sel, input bit gaps);
      int n, nw, k;
      n  = msg_q.size();
      nw = (n + 3) / 4;
      sel_v = sel;
      @(posedge clock); #1;
      if (sel) start2 = 1'b1; else start1 = 1'b1;
      @(posedge clock); #1;
      start1 = 1'b0;
      start2 = 1'b0;
      for (int w = 0; w < nw; w++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            d_valid = 1'b0;
            @(posedge clock); #1;
         end
         d_data = $urandom;
         for (int b = 0; b < 4; b++)
            if (4 * w + b < n) d_data[31 - 8 * b -: 8] = msg_q[4 * w + b];
         d_last  = (w == nw - 1);
         d_bytes = d_last ? 2'(n % 4) : 2'd0;
         d_valid = 1'b1;
         k = 0;
         while (!rdy_s && k < 200) begin
            @(posedge clock); #1;
            k++;
         end
         if (!rdy_s) begin
            checks++;
            errors++;
            $display("FAIL ready-timeout word=%0d", w);
            break;
         end
         @(posedge clock); #1;
      end
      d_valid = 1'b0;
      d_last  = 1'b0;
   endtask

   task automatic run_check(input bit sel, input bit gaps,
                            input string tag);
      int maxb, nexp, k;
      bit eovf;
      logic [15:0]  ga[$];
      logic [511:0] gd[$];
      build_model();
      q1a.delete(); q1d.delete(); q2a.delete(); q2d.delete();
      send_msg(sel, gaps);
      k = 0;
      while (!done_s && k < 500) begin
         @(posedge clock); #1;
         k++;
      end
      if (!done_s) begin
         checks++;
         errors++;
         $display("FAIL %s done-timeout", tag);
      end
      @(negedge clock); #1;
      if (sel) begin ga = q2a; gd = q2d; end
      else begin ga = q1a; gd = q1d; end
      maxb = sel ? 2 : 2000;
      eovf = exp_q.size() > maxb;
      nexp = eovf ? maxb : exp_q.size();
      chk({tag, " nwr"}, 64'(gd.size()), 64'(nexp));
      for (int i = 0; i < nexp && i < gd.size(); i++) begin
         chk({tag, " addr"}, 64'(ga[i]), 64'(i));
         chk512({tag, " block"}, gd[i], exp_q[i]);
      end
      chk({tag, " overflow"}, 64'(ovf_s), 64'(eovf));
      chk({tag, " last_addr"}, 64'(la_s), 64'(nexp - 1));
      chk({tag, " nonce_addr"}, 64'(nad_s), 64'(EXP_NADDR));
      chk({tag, " width"}, 64'(wid_s), 64'(EXP_WIDTH));
      if (!sel && !eovf)
         chk({tag, " done_lat"}, 64'(dr1), 64'(lw1 + 1));
   endtask

   task automatic check_zero(input string tag);
      chk512({tag, " message"}, msg1, '0);
      chk({tag, " indirizzo"}, 64'(ind1), 64'd0);
      chk({tag, " wr_en"}, 64'(wr1), 64'd0);
      chk({tag, " done"}, 64'(done1), 64'd0);
      chk({tag, " last_addr"}, 64'(la1), 64'd0);
      chk({tag, " nonce_addr"}, 64'(nad1), 64'd0);
      chk({tag, " width"}, 64'(wid1), 64'd0);
      chk({tag, " overflow"}, 64'(ovf1), 64'd0);
      chk({tag, " in_ready"}, 64'(if1.in_ready), 64'd0);
   endtask

   typedef struct {
      int          nbytes;
      logic [7:0]  fill;
      int          nwr;
      logic [15:0] last;
      int          pblk;
      int          pword;
      logic [31:0] pval;
      logic [31:0] w15;
   } vec_t;

   vec_t tbl[6];

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{56, 8'hAA, 2, 16'd1, 0, 14, 32'h8000_0000, 32'h0000_01C0};
      tbl[1] = '{64, 8'h3C, 2, 16'd1, 1, 0, 32'h8000_0000, 32'h0000_0200};
      tbl[2] = '{80, 8'h5C, 2, 16'd1, 1, 4, 32'h8000_0000, 32'h0000_0280};
      tbl[3] = '{1, 8'h11, 1, 16'd0, 0, 0, 32'h1180_0000, 32'h0000_0008};
      tbl[4] = '{55, 8'hAA, 1, 16'd0, 0, 13, 32'hAAAA_AA80, 32'h0000_01B8};
      tbl[5] = '{63, 8'h33, 2, 16'd1, 0, 15, 32'h3333_3380, 32'h0000_01F8};

      repeat (3) @(posedge clock);
      #1;
      check_zero("reset");
      reset = 1'b0;

      msg_q.delete();
      msg_q.push_back(8'h61);
      msg_q.push_back(8'h62);
      msg_q.push_back(8'h63);
      run_check(1'b0, 1'b0, "abc");
      if (q1d.size() > 0) begin
         chk512("abc exact", q1d[0], ABC);
         chk("abc addr", 64'(q1a[0]), 64'd0);
      end

      foreach (tbl[r]) begin
         msg_q.delete();
         for (int i = 0; i < tbl[r].nbytes; i++) msg_q.push_back(tbl[r].fill);
         run_check(1'b0, 1'b0, "row");
         chk("row nwr", 64'(q1d.size()), 64'(tbl[r].nwr));
         chk("row last", 64'(la1), 64'(tbl[r].last));
         if (q1d.size() == tbl[r].nwr) begin
            chk("row pad", 64'(word_of(q1d[tbl[r].pblk], tbl[r].pword)),
                64'(tbl[r].pval));
            chk("row len", 64'(word_of(q1d[tbl[r].nwr - 1], 15)),
                64'(tbl[r].w15));
         end
      end

      for (int r = 0; r < 10; r++) begin
         int n;
         n = $urandom_range(1, 200);
         msg_q.delete();
         for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
         run_check(1'b0, 1'b1, "rnd");
      end

      msg_q.delete();
      for (int i = 0; i < 128; i++) msg_q.push_back(8'($urandom));
      run_check(1'b1, 1'b0, "ovf");
      chk("ovf done", 64'(done2), 64'd1);
      @(posedge clock); #1;
      start2 = 1'b1;
      @(posedge clock); #1;
      start2 = 1'b0;
      chk("ovf clr done", 64'(done2), 64'd0);
      chk("ovf clr flag", 64'(ovf2), 64'd0);

      sel_v = 1'b0;
      @(posedge clock); #1;
      start1 = 1'b1;
      @(posedge clock); #1;
      start1 = 1'b0;
      for (int w = 0; w < 9; w++) begin
         d_data  = $urandom;
         d_last  = 1'b0;
         d_valid = 1'b1;
         @(posedge clock); #1;
      end
      d_data = $urandom;
      #2;
      reset = 1'b1;
      #1;
      check_zero("midrst");
      d_valid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;

      msg_q.delete();
      msg_q.push_back(8'h61);
      msg_q.push_back(8'h62);
      msg_q.push_back(8'h63);
      run_check(1'b0, 1'b0, "abc2");
      if (q1d.size() > 0) begin
         chk512("abc2 exact", q1d[0], ABC);
         chk("abc2 addr", 64'(q1a[0]), 64'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
